decryption_arbiter: RTL and testbench
=====================================

// Module: decryption_arbiter
// PURPOSE
// - Shares one caesar_decryption engine between two requester streams (req 0, req 1).
// - Packet-level round-robin arbitration; a grant is held until the packet's last word is accepted.
// - Latches the granted requester's key, sequences words into the engine, and tags engine results with requester id and last flag.
// - Sits between the input demux and the shared decryptor; its output feeds the result mux.
// PARAMETERS
// - D_WIDTH    8   data word width
// - KEY_WIDTH  16  key width; matches the engine
// - ENG_LAT    1   engine latency in cycles, from eng_valid_o high to eng_valid_i high (>=1)
// PORTS
// - clk          in   1            clock; all state changes on posedge
// - rst          in   1            asynchronous, active-high reset
// - data_i       in   2*D_WIDTH    [D_WIDTH-1:0] = req0, upper half = req1
// - valid_i      in   2            per-requester word valid
// - last_i       in   2            per-requester last word of packet
// - key_i        in   2*KEY_WIDTH  per-requester key; sampled at grant
// - busy_o       out  2            1 = requester must hold its word
// - eng_data_o   out  D_WIDTH      to engine data_i
// - eng_valid_o  out  1            to engine valid_i
// - eng_key_o    out  KEY_WIDTH    to engine key
// - eng_data_i   in   D_WIDTH      from engine data_o
// - eng_valid_i  in   1            from engine valid_o
// - data_o       out  D_WIDTH      decrypted word
// - valid_o      out  1            data_o valid
// - id_o         out  1            requester the word belongs to
// - last_o       out  1            last word of packet
// - err_o        out  1            sticky: eng_valid_i disagrees with expected tag
// BEHAVIOUR
// - Reset values
//   - state = IDLE, rr_ptr = 0, busy_o = 2'b11, eng_* = 0, tag line cleared, err_o = 0.
//   - valid_o, last_o, id_o = 0.
// - States: IDLE, GRANT, DRAIN (2-bit encoding).
// - IDLE
//   - busy_o = 11.
//   - If valid_i != 0: gnt <= winner; eng_key_o <= key_i[winner]; next state GRANT.
//   - Winner = rr_ptr if valid_i[rr_ptr] is high, otherwise the other requester.
// - GRANT
//   - busy_o[gnt] = 0; busy_o[~gnt] = 1.
//   - Accept = valid_i[gnt] & ~busy_o[gnt].
//   - On accept: eng_data_o <= data_i[gnt], eng_valid_o <= 1, push tag {1,gnt,last_i[gnt]}.
//   - Otherwise: eng_valid_o <= 0, push tag {0,x,0}.
//   - Idle gaps are allowed and the grant is held through them.
//   - Accepting a word with last_i=1 -> DRAIN, drain_cnt <= ENG_LAT.
// - DRAIN
//   - busy_o = 11; eng_valid_o <= 0; empty tags pushed.
//   - drain_cnt decrements each cycle.
//   - At 0: rr_ptr <= ~gnt; next state IDLE.
// - Latency
//   - A word accepted at edge t appears on eng_valid_o during cycle t+1.
//   - Its result appears on data_o/valid_o ENG_LAT cycles later.
//   - data_o/valid_o are combinational from eng_data_i and the tag line.
// - Tag line
//   - ENG_LAT+1 deep shift register, aligned with eng_valid_i.
//   - valid_o = tag.v; id_o = tag.id; last_o = tag.v & tag.last; data_o = eng_data_i.
//   - eng_valid_i is not used to qualify valid_o.
//   - eng_valid_i != tag.v -> err_o <= 1; it stays set until reset.
// - Key
//   - eng_key_o is constant for the whole packet; key_i changes mid-packet are ignored.
// - Fairness
//   - Both requesters valid in IDLE -> rr_ptr wins.
//   - After any packet, the other requester has priority.
//   - Single-word packet: last on the first word; back-to-back grants alternate.
// - Reset mid-packet
//   - All state is cleared asynchronously.
//   - In-flight engine results are discarded, because valid_o comes from the cleared tags.
// - Arithmetic is done in the engine; this block never modifies data.
// STRUCTURE
// - decryption_defs.vh: state encodings, tag field offsets, REQ_ID_W = 1.
// - One sub-module: arb_tag_delay (parameter DEPTH, WIDTH), an async-reset shift register for tags.
// TESTING
// - Req0 only, key=3, words 0x44,0x45(last)
//   -> eng_key_o=3; data_o 0x41,0x42; id_o=0; last_o on the second word; back to IDLE.
// - Req0 and req1 valid in the same IDLE cycle after reset
//   -> req0 packet first, then req1; busy_o[1]=1 throughout the req0 packet.
// - Req0 sends 3 words with a 2-cycle valid gap mid-packet
//   -> grant held; req1 stays busy; 3 outputs in order; no spurious valid_o.
// - Req1 changes key_i from 5 to 9 mid-packet
//   -> every word decrypted with 5.
// - rst pulsed while 2 words are in flight
//   -> valid_o=0 from the reset edge; busy_o=11; rr_ptr=0; err_o=0.
// - Engine model asserts eng_valid_i one cycle early
//   -> err_o=1 and stays 1 until rst.

Source files
------------

// File: rtl/decryption_arbiter_pkg.sv
// Shared definitions for the decryption arbiter: FSM states, tag layout and
// a helper to assemble a tag word.
package decryption_arbiter_pkg;

    // Width of a requester id (two requesters)
    localparam int REQ_ID_W = 1;

    // Tag layout: {valid, id, last}
    localparam int TAG_LAST = 0;
    localparam int TAG_ID   = 1;
    localparam int TAG_V    = TAG_ID + REQ_ID_W;
    localparam int TAG_W    = TAG_V + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] make_tag(
        input logic                v,
        input logic [REQ_ID_W-1:0] id,
        input logic                last
    );
        return {v, id, last};
    endfunction

endpackage

// File: rtl/decryption_arbiter_tag_delay.sv
// Tag delay line: a DEPTH-stage shift register that carries the
// {valid, id, last} tag of each engine slot so it lines up with the
// engine's result.
module arb_tag_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

    // Shift one tag per cycle; reset clears every in-flight tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            stage_reg[0] <= din;
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/decryption_arbiter.sv
// Packet-level round-robin arbiter sharing one decryption engine between two
// requesters. Holds the grant until the last word, latches the key at grant,
// and tags engine results with requester id and last flag.
module decryption_arbiter
    import decryption_arbiter_pkg::*;
#(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 16,
    parameter int ENG_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*D_WIDTH-1:0]   data_i,
    input  logic [1:0]             valid_i,
    input  logic [1:0]             last_i,
    input  logic [2*KEY_WIDTH-1:0] key_i,
    output logic [1:0]             busy_o,
    output logic [D_WIDTH-1:0]     eng_data_o,
    output logic                   eng_valid_o,
    output logic [KEY_WIDTH-1:0]   eng_key_o,
    input  logic [D_WIDTH-1:0]     eng_data_i,
    input  logic                   eng_valid_i,
    output logic [D_WIDTH-1:0]     data_o,
    output logic                   valid_o,
    output logic                   id_o,
    output logic                   last_o,
    output logic                   err_o
);

    localparam int CNT_W = (ENG_LAT < 1) ? 1 : $clog2(ENG_LAT + 1);

    state_t                state_reg, state_next;
    logic [REQ_ID_W-1:0]   gnt_reg;
    logic [REQ_ID_W-1:0]   rr_ptr_reg;
    logic [REQ_ID_W-1:0]   winner;
    logic [CNT_W-1:0]      drain_cnt_reg;
    logic                  err_reg;
    logic                  accept;
    logic                  gnt_last;
    logic [D_WIDTH-1:0]    gnt_data;
    logic [KEY_WIDTH-1:0]  winner_key;
    logic [TAG_W-1:0]      tag_in;
    logic [TAG_W-1:0]      tag_out;

    // Requester-side muxes: granted word and the key of the IDLE winner
    assign winner     = valid_i[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;
    assign gnt_data   = gnt_reg[0] ? data_i[2*D_WIDTH-1:D_WIDTH] : data_i[D_WIDTH-1:0];
    assign gnt_last   = last_i[gnt_reg];
    assign winner_key = winner[0] ? key_i[2*KEY_WIDTH-1:KEY_WIDTH] : key_i[KEY_WIDTH-1:0];

    // Next-state, handshake and tag generation
    always_comb begin
        state_next = state_reg;
        busy_o     = 2'b11;
        accept     = 1'b0;
        tag_in     = make_tag(1'b0, '0, 1'b0);
        case (state_reg)
            ST_IDLE: begin
                if (valid_i != 2'b00) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                busy_o = gnt_reg[0] ? 2'b01 : 2'b10;
                accept = valid_i[gnt_reg];
                if (accept) begin
                    tag_in = make_tag(1'b1, gnt_reg, gnt_last);
                    if (gnt_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant, key latch, engine drive, drain counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_reg       <= '0;
            rr_ptr_reg    <= '0;
            drain_cnt_reg <= '0;
            eng_data_o    <= '0;
            eng_valid_o   <= 1'b0;
            eng_key_o     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    eng_valid_o <= 1'b0;
                    if (valid_i != 2'b00) begin
                        gnt_reg   <= winner;
                        eng_key_o <= winner_key;
                    end
                end
                ST_GRANT: begin
                    eng_valid_o <= accept;
                    if (accept) begin
                        eng_data_o <= gnt_data;
                        if (gnt_last) begin
                            drain_cnt_reg <= CNT_W'(ENG_LAT);
                        end
                    end
                end
                ST_DRAIN: begin
                    eng_valid_o <= 1'b0;
                    if (drain_cnt_reg == '0) begin
                        rr_ptr_reg <= ~gnt_reg;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
                    end
                end
                default: eng_valid_o <= 1'b0;
            endcase
        end
    end

    // Sticky error: engine valid disagrees with the tag expected this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (eng_valid_i != tag_out[TAG_V]) begin
            err_reg <= 1'b1;
        end
    end

    arb_tag_delay #(
        .DEPTH (ENG_LAT + 1),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign data_o  = eng_data_i;
    assign valid_o = tag_out[TAG_V];
    assign id_o    = tag_out[TAG_ID];
    assign last_o  = tag_out[TAG_V] & tag_out[TAG_LAST];
    assign err_o   = err_reg;

endmodule

// File: tb/tb_decryption_arbiter.sv
// Scoreboard bench for decryption_arbiter with a behavioural Caesar engine
// (out = in - key[7:0], one-cycle latency, optional early-valid fault mode).
module tb_decryption_arbiter;

    localparam int ENG_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d0, d1;
    logic        v0, v1, l0, l1;
    logic [15:0] k0, k1;
    logic [1:0]  busy_o;
    logic [7:0]  eng_data_o, eng_data_i, data_o;
    logic        eng_valid_o, eng_valid_i, valid_o, id_o, last_o, err_o;
    logic [15:0] eng_key_o;
    logic        early;
    logic [7:0]  eng_q;
    logic        eng_vq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic       id;
        logic       last;
        int         cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] key_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decryption_arbiter #(.D_WIDTH(8), .KEY_WIDTH(16), .ENG_LAT(ENG_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      ({d1, d0}),
        .valid_i     ({v1, v0}),
        .last_i      ({l1, l0}),
        .key_i       ({k1, k0}),
        .busy_o      (busy_o),
        .eng_data_o  (eng_data_o),
        .eng_valid_o (eng_valid_o),
        .eng_key_o   (eng_key_o),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .id_o        (id_o),
        .last_o      (last_o),
        .err_o       (err_o)
    );

    // Behavioural engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_q  <= 8'h00;
            eng_vq <= 1'b0;
        end else begin
            eng_q  <= eng_data_o - eng_key_o[7:0];
            eng_vq <= eng_valid_o;
        end
    end
    assign eng_data_i  = early ? (eng_data_o - eng_key_o[7:0]) : eng_q;
    assign eng_valid_i = early ? eng_valid_o : eng_vq;

    // Monitor: checks engine key and output words against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (busy_o == 2'b00) begin
                n_fail++;
                $display("FAIL busy_both_low: busy_o=%b required not 00", busy_o);
            end
            if (eng_valid_o) begin
                n_checks++;
                if (key_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_eng_valid: eng_valid_o=1 with nothing accepted");
                end else begin
                    logic [15:0] ek;
                    ek = key_q.pop_front();
                    if (eng_key_o !== ek) begin
                        n_fail++;
                        $display("FAIL eng_key: got %h required %h", eng_key_o, ek);
                    end
                end
            end
            if (valid_o) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_valid_o: data=%h id=%0d", data_o, id_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (data_o !== e.data || id_o !== e.id || last_o !== e.last || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL out_word: got data=%h id=%0d last=%0d cyc=%0d required data=%h id=%0d last=%0d cyc=%0d",
                                 data_o, id_o, last_o, cyc, e.data, e.id, e.last, e.cyc);
                    end else begin
                        $display("out word data=%h id=%0d last=%0d cyc=%0d", data_o, id_o, last_o, cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Drive one word on requester r and wait until it is accepted
    task automatic send_word(input bit r, input logic [7:0] w, input logic [7:0] e,
                             input logic last, input logic [15:0] key,
                             input logic [15:0] exp_key, output int acc_cyc);
        bit done = 0;
        acc_cyc = -1;
        if (r == 1'b0) begin
            d0 = w; l0 = last; k0 = key; v0 = 1'b1;
        end else begin
            d1 = w; l1 = last; k1 = key; v1 = 1'b1;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy_o[r]) begin
                sb_q.push_back('{e, r, last, cyc + 1 + ENG_LAT});
                key_q.push_back(exp_key);
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req%0d word %h not accepted", r, w);
        end
    endtask

    task automatic release_req(input bit r);
        if (r == 1'b0) begin
            v0 = 1'b0; l0 = 1'b0;
        end else begin
            v1 = 1'b0; l1 = 1'b0;
        end
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb_q.delete();
        key_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, b0, b1, cnt;
        rst = 1'b1; early = 1'b0;
        d0 = 0; d1 = 0; v0 = 0; v1 = 0; l0 = 0; l1 = 0; k0 = 0; k1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 32'h3);
        chk("rst_valid_o", 32'({valid_o, last_o, id_o}), 32'h0);
        chk("rst_eng", 32'({eng_valid_o, eng_data_o, eng_key_o}), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: req0 only, key 3
        $display("T1 req0 key=3 words 44,45");
        send_word(0, 8'h44, 8'h41, 1'b0, 16'd3, 16'd3, a0);
        send_word(0, 8'h45, 8'h42, 1'b1, 16'd3, 16'd3, a0);
        release_req(0);
        drain_wait();
        chk("t1_idle_busy", 32'(busy_o), 32'h3);
        chk("t1_err", 32'(err_o), 32'h0);

        // T2: both valid in the same IDLE cycle after reset -> req0 first
        pulse_reset();
        $display("T2 req0 and req1 together");
        fork
            begin
                send_word(0, 8'h70, 8'h60, 1'b0, 16'h0010, 16'h0010, a0);
                send_word(0, 8'h71, 8'h61, 1'b1, 16'h0010, 16'h0010, a1);
                release_req(0);
            end
            begin
                send_word(1, 8'h33, 8'h31, 1'b0, 16'h0102, 16'h0102, b0);
                send_word(1, 8'h34, 8'h32, 1'b1, 16'h0102, 16'h0102, b1);
                release_req(1);
            end
        join
        drain_wait();
        chk("t2_req1_after_req0", 32'(b0 > a1), 32'd1);
        chk("t2_err", 32'(err_o), 32'h0);

        // T3: req0 3 words with a 2-cycle gap; req1 waits
        $display("T3 req0 gap packet, req1 waiting");
        fork
            begin
                send_word(0, 8'h50, 8'h49, 1'b0, 16'd7, 16'd7, a0);
                release_req(0);
                repeat (2) begin
                    @(negedge clk);
                    chk("t3_gap_busy", 32'(busy_o), 32'h2);
                    @(posedge clk);
                end
                #1;
                send_word(0, 8'h51, 8'h4A, 1'b0, 16'd7, 16'd7, a0);
                send_word(0, 8'h52, 8'h4B, 1'b1, 16'd7, 16'd7, a1);
                release_req(0);
            end
            begin
                @(posedge clk);
                #1;
                send_word(1, 8'h21, 8'h20, 1'b1, 16'd1, 16'd1, b0);
                release_req(1);
            end
        join
        drain_wait();
        chk("t3_req1_after_req0", 32'(b0 > a1), 32'd1);
        chk("t3_err", 32'(err_o), 32'h0);

        // T4: req1 key changes 5 -> 9 mid-packet; all words use 5
        $display("T4 req1 key change mid-packet");
        send_word(1, 8'h48, 8'h43, 1'b0, 16'd5, 16'd5, a0);
        send_word(1, 8'h49, 8'h44, 1'b0, 16'd9, 16'd5, a0);
        send_word(1, 8'h4A, 8'h45, 1'b1, 16'd9, 16'd5, a0);
        release_req(1);
        drain_wait();
        chk("t4_err", 32'(err_o), 32'h0);

        // T5: move rr_ptr to 1, then reset with two req1 words in flight
        $display("T5 reset with words in flight");
        send_word(0, 8'h10, 8'h10, 1'b1, 16'd0, 16'd0, a0);
        release_req(0);
        drain_wait();
        d1 = 8'h80; l1 = 1'b0; k1 = 16'd0; v1 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50 && cnt < 2; i++) begin
            @(negedge clk);
            if (!busy_o[1]) begin
                key_q.push_back(16'd0);
                cnt++;
            end
            @(posedge clk);
            #1;
            d1 = 8'h81;
        end
        chk("t5_two_accepted", 32'(cnt), 32'd2);
        rst = 1'b1;
        #1;
        chk("t5_valid_o", 32'(valid_o), 32'h0);
        chk("t5_busy", 32'(busy_o), 32'h3);
        chk("t5_err", 32'(err_o), 32'h0);
        chk("t5_eng_valid", 32'(eng_valid_o), 32'h0);
        release_req(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb_q.delete();
        key_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                send_word(0, 8'h66, 8'h65, 1'b1, 16'd1, 16'd1, a0);
                release_req(0);
            end
            begin
                send_word(1, 8'h77, 8'h76, 1'b1, 16'd1, 16'd1, b0);
                release_req(1);
            end
        join
        drain_wait();
        chk("t5_rr_reset_req0_first", 32'(a0 < b0), 32'd1);

        // T6: engine valid one cycle early -> sticky err_o until reset
        $display("T6 early engine valid");
        early = 1'b1;
        send_word(0, 8'h39, 8'h37, 1'b1, 16'd2, 16'd2, a0);
        release_req(0);
        drain_wait();
        early = 1'b0;
        chk("t6_err_set", 32'(err_o), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_err_sticky", 32'(err_o), 32'h1);
        pulse_reset();
        chk("t6_err_cleared", 32'(err_o), 32'h0);

        chk("end_key_q_empty", 32'(key_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
